// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
//   GW     : bits per lookahead group
//   NSTAGE : number of register stages (valid bits are kept as an NSTAGE-wide vector)
package cla_pkg;

  localparam int unsigned GW     = 4;
  localparam int unsigned NSTAGE = 2;

  // Adds a late-arriving group carry-in to a group sum that was formed with carry-in 0.
  // The carry out of this increment is not needed: the lookahead prefix already
  // accounts for it in the next group's carry-in.
  function automatic logic [GW-1:0] grp_inc(logic [GW-1:0] s, logic c);
    return s + {{(GW-1){1'b0}}, c};
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bus for cla_addsub_pipe.
//   in_valid/in_ready   : operand handshake (A, B, C0, sub)
//   out_valid/out_ready : result handshake (sum, carry, ovf)
// master = producer of operands / consumer of results; slave = the adder.
interface cla_addsub_pipe_if #(
  parameter int unsigned m = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [m-1:0] A;
  logic [m-1:0] B;
  logic         C0;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [m:0]   sum;
  logic         carry;
  logic         ovf;

  modport master (
    output in_valid, A, B, C0, sub, out_ready,
    input  in_ready, out_valid, sum, carry, ovf
  );

  modport slave (
    input  in_valid, A, B, C0, sub, out_ready,
    output in_ready, out_valid, sum, carry, ovf
  );

endinterface

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group.
//   a_i, b_i : group operand bits
//   c_i      : group carry-in
//   g_o, p_o : group generate / propagate (independent of c_i)
//   s_o      : group sum using c_i
module cla_group4
  import cla_pkg::*;
(
  input  logic [GW-1:0] a_i,
  input  logic [GW-1:0] b_i,
  input  logic          c_i,
  output logic          g_o,
  output logic          p_o,
  output logic [GW-1:0] s_o
);

  logic [GW-1:0] g;
  logic [GW-1:0] p;
  logic [GW-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Flattened lookahead inside the group; no bit-to-bit ripple.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;
  assign s_o = p ^ c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : cla_addsub_pipe_if slave (operands in, results out)
// S1 holds per-group G/P, per-group sums formed with group carry-in 0 (group 0 uses the
// real carry-in), the effective carry-in and the operand sign bits. The S1->S2 path
// resolves group carries with a Kogge-Stone prefix and increments each group sum.
// m must be a multiple of GW and at least 8.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned m = 16
) (
  input logic              clk,
  input logic              rst_n,
  cla_addsub_pipe_if.slave bus
);

  localparam int unsigned NG   = m / GW;
  localparam int unsigned NC   = NG + 1;  // prefix element 0 carries the external carry-in
  localparam int unsigned NLVL = $clog2(NC);

  // ---------------------------------------------------------------- stage 0 (comb)
  logic [m-1:0]  b_eff;
  logic          cin_eff;
  logic [NG-1:0] grp_cin;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [m-1:0]  grp_s;

  // Subtraction is A + ~B + ~C0; a borrow-in becomes an inverted carry-in.
  assign b_eff   = bus.sub ? ~bus.B : bus.B;
  assign cin_eff = bus.sub ? ~bus.C0 : bus.C0;
  assign grp_cin = {{(NG-1){1'b0}}, cin_eff};

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .a_i (bus.A[gi*GW +: GW]),
      .b_i (b_eff[gi*GW +: GW]),
      .c_i (grp_cin[gi]),
      .g_o (grp_g[gi]),
      .p_o (grp_p[gi]),
      .s_o (grp_s[gi*GW +: GW])
    );
  end

  // ---------------------------------------------------------------- state
  logic [NSTAGE-1:0] vld_q, vld_d;  // [0] = S1 valid, [1] = S2 valid
  logic [NG-1:0]     s1_g_q, s1_g_d;
  logic [NG-1:0]     s1_p_q, s1_p_d;
  logic [m-1:0]      s1_s_q, s1_s_d;
  logic              s1_cin_q, s1_cin_d;
  logic              s1_sub_q, s1_sub_d;
  logic              s1_a_msb_q, s1_a_msb_d;
  logic              s1_b_msb_q, s1_b_msb_d;
  logic [m:0]        sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;

  // ---------------------------------------------------------------- handshake
  logic s2_ready;
  logic s1_adv;
  logic in_ready;
  logic in_fire;

  assign s2_ready = ~vld_q[1] | bus.out_ready;
  assign s1_adv   = vld_q[0] & s2_ready;
  assign in_ready = ~vld_q[0] | s2_ready;
  assign in_fire  = bus.in_valid & in_ready;

  // ---------------------------------------------------------------- S1 -> S2 (comb)
  logic [NC-1:0] pfx_g [NLVL+1];
  logic [NC-1:0] pfx_p [NLVL+1];
  logic [NC-1:0] gcar;
  logic [m-1:0]  sum_lo;
  logic          carry_int;
  logic          carry_nx;
  logic          ovf_nx;

  // After the last level, pfx_g[NLVL][i] is the carry into group i.
  always_comb begin
    pfx_g[0] = {s1_g_q, s1_cin_q};
    pfx_p[0] = {s1_p_q, 1'b0};
    for (int l = 0; l < int'(NLVL); l++) begin
      pfx_g[l+1] = pfx_g[l];
      pfx_p[l+1] = pfx_p[l];
      for (int i = (1 << l); i < int'(NC); i++) begin
        pfx_g[l+1][i] = pfx_g[l][i] | (pfx_p[l][i] & pfx_g[l][i-(1<<l)]);
        pfx_p[l+1][i] = pfx_p[l][i] & pfx_p[l][i-(1<<l)];
      end
    end
  end

  assign gcar = pfx_g[NLVL];

  // Group 0 already absorbed the carry-in in stage 0.
  always_comb begin
    sum_lo = '0;
    for (int i = 0; i < int'(NG); i++) begin
      sum_lo[i*GW +: GW] = grp_inc(s1_s_q[i*GW +: GW], (i != 0) && gcar[i]);
    end
  end

  assign carry_int = gcar[NG];
  assign carry_nx  = s1_sub_q ^ carry_int;
  assign ovf_nx    = (s1_a_msb_q == s1_b_msb_q) & (sum_lo[m-1] != s1_a_msb_q);

  // ---------------------------------------------------------------- next state
  always_comb begin
    vld_d      = vld_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_s_d     = s1_s_q;
    s1_cin_d   = s1_cin_q;
    s1_sub_d   = s1_sub_q;
    s1_a_msb_d = s1_a_msb_q;
    s1_b_msb_d = s1_b_msb_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;

    if (in_fire) begin
      vld_d[0]   = 1'b1;
      s1_g_d     = grp_g;
      s1_p_d     = grp_p;
      s1_s_d     = grp_s;
      s1_cin_d   = cin_eff;
      s1_sub_d   = bus.sub;
      s1_a_msb_d = bus.A[m-1];
      s1_b_msb_d = b_eff[m-1];
    end else if (s1_adv) begin
      vld_d[0] = 1'b0;
    end

    if (s2_ready) begin
      vld_d[1] = vld_q[0];
      if (vld_q[0]) begin
        sum_d   = {carry_nx, sum_lo};
        carry_d = carry_nx;
        ovf_d   = ovf_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_s_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_a_msb_q <= 1'b0;
      s1_b_msb_q <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      s1_g_q     <= s1_g_d;
      s1_p_q     <= s1_p_d;
      s1_s_q     <= s1_s_d;
      s1_cin_q   <= s1_cin_d;
      s1_sub_q   <= s1_sub_d;
      s1_a_msb_q <= s1_a_msb_d;
      s1_b_msb_q <= s1_b_msb_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q[1];
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;

endmodule
